// File: rtl/rf_sb_if.sv
// Bundle of the decode/writeback signals that connect the pipeline to the
// register file and scoreboard.
interface rf_sb_if #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32,
  parameter int N_RD    = 2
) ();
  logic                      we;
  logic [A_WIDTH-1:0]        wa;
  logic [D_WIDTH-1:0]        wd;
  logic [N_RD*A_WIDTH-1:0]   ra;
  logic [N_RD*D_WIDTH-1:0]   rd;
  logic [N_RD-1:0]           rd_busy;
  logic                      issue_en;
  logic [A_WIDTH-1:0]        issue_ad;
  logic                      issue_stall;
  logic [A_WIDTH:0]          pend_cnt;
  logic [D_WIDTH-1:0]        a0;

  modport master (
    output we, wa, wd, ra, issue_en, issue_ad,
    input  rd, rd_busy, issue_stall, pend_cnt, a0
  );

  modport slave (
    input  we, wa, wd, ra, issue_en, issue_ad,
    output rd, rd_busy, issue_stall, pend_cnt, a0
  );
endinterface

// File: rtl/rf_sb.sv
// Register file with write-first bypass, hardwired x0, and a pending-destination
// scoreboard that decode uses for RAW/WAW hazard stalls.
module rf_sb #(
  parameter int A_WIDTH = 5,
  parameter int D_WIDTH = 32,
  parameter int N_RD    = 2,
  parameter int A0_IDX  = 10
) (
  input  logic   clk,
  input  logic   rst,
  rf_sb_if.slave bus
);
  localparam int NREG = 2 ** A_WIDTH;
  localparam int CW   = A_WIDTH + 1;

  logic [D_WIDTH-1:0] regs_q [NREG];
  logic [D_WIDTH-1:0] regs_d [NREG];
  logic [NREG-1:0]    pend_q, pend_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic wr_hit;
  logic stall;
  logic iss_ok;
  logic inc;
  logic dec;

  assign wr_hit = bus.we && (bus.wa != '0);
  assign stall  = bus.issue_en && (bus.issue_ad != '0) && pend_q[bus.issue_ad] &&
                  !(bus.we && (bus.wa == bus.issue_ad));
  assign iss_ok = bus.issue_en && (bus.issue_ad != '0) && !stall;

  // Count tracks population of pending; a set-over-clear on one register is a no-op.
  assign inc = iss_ok && !pend_q[bus.issue_ad];
  assign dec = wr_hit && pend_q[bus.wa] && !(iss_ok && (bus.issue_ad == bus.wa));

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (wr_hit) begin
      regs_d[bus.wa] = bus.wd;
      pend_d[bus.wa] = 1'b0;
    end
    if (iss_ok) begin
      pend_d[bus.issue_ad] = 1'b1;
    end
    pend_d[0] = 1'b0;
    if (inc && !dec) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec && !inc) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Same-cycle writeback both forwards its data and satisfies a pending operand.
  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    logic [A_WIDTH-1:0] ra_i;
    logic               hit_i;
    assign ra_i  = bus.ra[i*A_WIDTH +: A_WIDTH];
    assign hit_i = bus.we && (bus.wa == ra_i);
    assign bus.rd[i*D_WIDTH +: D_WIDTH] = (ra_i == '0) ? '0 :
                                          hit_i        ? bus.wd : regs_q[ra_i];
    assign bus.rd_busy[i] = pend_q[ra_i] && !hit_i && (ra_i != '0);
  end

  assign bus.issue_stall = stall;
  assign bus.pend_cnt    = cnt_q;
  assign bus.a0          = regs_q[A_WIDTH'(A0_IDX)];
endmodule
